mem: RTL and testbench



---
 rtl/mem_pkg.sv | 13 +
 rtl/mem.sv | 71 +++++++
 tb/tb_mem.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the simple dual-port RAM.
// Default geometry is 100 words of 8 bits; depth need not be a power of two.
package mem_pkg;

    localparam int unsigned MEM_WIDTH = 8;
    localparam int unsigned MEM_DEPTH = 100;

    // The address space is 2^ADDR_W, so addresses at or above depth exist but map to no word.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/mem.sv
// Simple dual-port synchronous RAM with a registered read and one-cycle latency.
// A read and a write to the same address on the same edge return the new data.
module mem
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = MEM_WIDTH,
    parameter int unsigned DEPTH = MEM_DEPTH,
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              addr_err
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             addr_err_q, addr_err_d;
    logic             wr_ok, rd_ok;
    logic             wr_go;

    assign wr_ok = addr_in_range(32'(wr_addr), DEPTH);
    assign rd_ok = addr_in_range(32'(rd_addr), DEPTH);
    assign wr_go = wr_en && wr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_go) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (!rd_ok) begin
                rd_data_d = '0;
            end else if (wr_go && (wr_addr == rd_addr)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem_q[rd_addr];
            end
        end
    end

    always_comb begin
        addr_err_d = (wr_en && !wr_ok) || (rd_en && !rd_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: directed plan cases followed by randomized traffic,
// all compared against a plain array model of the RAM.
module tb_mem;

    localparam int unsigned W = 8;
    localparam int unsigned D = 100;

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en;
    logic [6:0] wr_addr, rd_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       addr_err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] ref_mem [D];
    logic [7:0] exp_rd;
    logic       exp_err;

    mem #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one edge of stimulus, advance the model, then compare both outputs.
    task automatic cycle(input logic r, input logic we, input int wa, input int wd,
                         input logic re, input int ra);
        rst     = r;
        wr_en   = we;
        wr_addr = 7'(wa);
        wr_data = 8'(wd);
        rd_en   = re;
        rd_addr = 7'(ra);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < int'(D); i++) ref_mem[i] = 8'h00;
            exp_rd  = 8'h00;
            exp_err = 1'b0;
        end else begin
            exp_err = (we && wa >= int'(D)) || (re && ra >= int'(D));
            if (re) begin
                if (ra >= int'(D))          exp_rd = 8'h00;
                else if (we && wa == ra)    exp_rd = 8'(wd);
                else                        exp_rd = ref_mem[ra];
            end
            if (we && wa < int'(D)) ref_mem[wa] = 8'(wd);
        end
        #1;
        check("rd_data", 32'(rd_data), 32'(exp_rd));
        check("addr_err", 32'(addr_err), 32'(exp_err));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        exp_rd = '0; exp_err = 1'b0;
        for (int i = 0; i < int'(D); i++) ref_mem[i] = 8'h00;

        cycle(1'b1, 1'b0, 0, 0, 1'b0, 0);
        check("reset_rd_data", 32'(rd_data), 32'h0);

        // Basic write then read
        cycle(1'b0, 1'b1, 2, 8'h01, 1'b0, 0);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 2);
        check("basic_read", 32'(rd_data), 32'h01);

        // Read hold while rd_en is low, then fresh read sees new value
        cycle(1'b0, 1'b1, 2, 8'hFF, 1'b0, 0);
        check("hold", 32'(rd_data), 32'h01);
        idle();
        check("hold2", 32'(rd_data), 32'h01);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 2);
        check("hold_reread", 32'(rd_data), 32'hFF);

        // Reset clears contents
        cycle(1'b0, 1'b1, 7, 8'hA5, 1'b0, 0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 0);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 7);
        check("reset_clears", 32'(rd_data), 32'h00);

        // Read-during-write, same address
        cycle(1'b0, 1'b1, 10, 8'h3C, 1'b1, 10);
        check("rdw_same", 32'(rd_data), 32'h3C);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 10);
        check("rdw_later", 32'(rd_data), 32'h3C);

        // Different addresses on the same edge: old contents of rd_addr
        cycle(1'b0, 1'b1, 11, 8'h5A, 1'b1, 10);
        check("rdw_diff", 32'(rd_data), 32'h3C);

        // Boundaries
        cycle(1'b0, 1'b1, 0, 8'h11, 1'b0, 0);
        cycle(1'b0, 1'b1, 99, 8'h99, 1'b1, 0);
        check("addr0", 32'(rd_data), 32'h11);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 99);
        check("addr99", 32'(rd_data), 32'h99);
        cycle(1'b0, 1'b1, 100, 8'h77, 1'b0, 0);
        check("oor_wr_err", 32'(addr_err), 32'h1);
        idle();
        check("oor_err_clears", 32'(addr_err), 32'h0);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 100);
        check("oor_rd_data", 32'(rd_data), 32'h00);
        check("oor_rd_err", 32'(addr_err), 32'h1);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 99);
        check("addr99_intact", 32'(rd_data), 32'h99);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 127);
        check("oor127", 32'(rd_data), 32'h00);

        // Reset mid-operation beats a simultaneous write and read
        cycle(1'b0, 1'b1, 20, 8'hC3, 1'b0, 0);
        cycle(1'b1, 1'b1, 20, 8'hEE, 1'b1, 20);
        check("rst_prio_rd", 32'(rd_data), 32'h00);
        check("rst_prio_err", 32'(addr_err), 32'h0);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 20);
        check("rst_prio_mem", 32'(rd_data), 32'h00);

        // Randomized traffic; addresses biased to collide and to stray out of range
        for (int n = 0; n < 1500; n++) begin
            int wa, ra;
            wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(95, 127))
                                             : int'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) ra = int'($urandom_range(0, 15));
            cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), wa,
                  int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ra);
        end

        // Sweep every word to confirm the model and RAM agree
        for (int a = 0; a < int'(D); a++) begin
            cycle(1'b0, 1'b0, 0, 0, 1'b1, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
